// File: rtl/gb80_bus_ctrl_pkg.sv
// Shared state type and widths for the GB80 memory bus controller.
// The optional timeout (GB80_BUS_TIMEOUT_EN) is disabled unless the build defines it.
package gb80_bus_ctrl_pkg;

  localparam int unsigned GB80_ADDR_W = 16;
  localparam int unsigned GB80_WAIT_W = 4;
  localparam int unsigned GB80_TMO_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADDR   = 2'd1,
    ST_STROBE = 2'd2,
    ST_DONE   = 2'd3
  } bus_state_e;

  // Byte address inside a little-endian access; wraps modulo 2^16.
  function automatic logic [GB80_ADDR_W-1:0] byte_addr(input logic [GB80_ADDR_W-1:0] base,
                                                        input logic                   idx);
    return base + {{(GB80_ADDR_W-1){1'b0}}, idx};
  endfunction

endpackage

// File: rtl/bus_wait_counter.sv
// Loadable down-counter with a zero flag; saturates at zero.
// Used for strobe wait states and, optionally, the bus timeout.
module bus_wait_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/gb80_bus_ctrl.sv
// GB80 memory bus controller: byte / little-endian word accesses with wait states.
// Define GB80_BUS_TIMEOUT_EN to build the extra-wait timeout (o_err); otherwise waits are unbounded.
module gb80_bus_ctrl
  import gb80_bus_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES    = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_we,
  input  logic        i_word,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_wdata,
  output logic        o_ready,
  output logic        o_done,
  output logic [15:0] o_rdata,
  output logic        o_err,
  output logic [15:0] o_mem_addr,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  output logic [7:0]  o_mem_wdata,
  input  logic [7:0]  i_mem_rdata,
  input  logic        i_mem_wait
);

  bus_state_e state_q, state_d;

  logic [GB80_ADDR_W-1:0] addr_q, mem_addr_q;
  logic [15:0]            rdata_q;
  logic [7:0]             wdata_hi_q, mem_wdata_q, b0_q;
  logic                   we_q, word_q, idx_q, err_q;
  logic                   wait_zero, phase_done, timeout, last_phase;
  logic [GB80_WAIT_W-1:0] wait_cnt_unused;

  bus_wait_counter #(
    .WIDTH (GB80_WAIT_W)
  ) u_wait_cnt (
    .clk_i      (i_clk),
    .rst_ni     (i_reset),
    .load_i     (state_q == ST_ADDR),
    .load_val_i (GB80_WAIT_W'(WAIT_CYCLES)),
    .dec_i      (state_q == ST_STROBE),
    .count_o    (wait_cnt_unused),
    .zero_o     (wait_zero)
  );

`ifdef GB80_BUS_TIMEOUT_EN
  logic [GB80_TMO_W-1:0] tmo_cnt;
  logic                  tmo_zero_unused, stall;

  assign stall = (state_q == ST_STROBE) && wait_zero && i_mem_wait;

  bus_wait_counter #(
    .WIDTH (GB80_TMO_W)
  ) u_tmo_cnt (
    .clk_i      (i_clk),
    .rst_ni     (i_reset),
    .load_i     (state_q == ST_ADDR),
    .load_val_i (GB80_TMO_W'(TIMEOUT_CYCLES)),
    .dec_i      (stall),
    .count_o    (tmo_cnt),
    .zero_o     (tmo_zero_unused)
  );

  // Counting down from the limit: the stall seen at count 1 is the limit-th one and aborts.
  assign timeout = stall && (tmo_cnt <= GB80_TMO_W'(1));
`else
  logic [GB80_TMO_W-1:0] tmo_unused;
  assign tmo_unused = GB80_TMO_W'(TIMEOUT_CYCLES);
  assign timeout    = 1'b0;
`endif

  assign phase_done = (state_q == ST_STROBE) && wait_zero && !i_mem_wait;
  assign last_phase = !word_q || idx_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (i_req) state_d = ST_ADDR;
      ST_ADDR:   state_d = ST_STROBE;
      ST_STROBE: begin
        if (timeout) begin
          state_d = ST_DONE;
        end else if (phase_done) begin
          state_d = last_phase ? ST_DONE : ST_ADDR;
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_ready     = (state_q == ST_IDLE);
    o_done      = (state_q == ST_DONE);
    o_err       = (state_q == ST_DONE) && err_q;
    o_mem_rd    = (state_q == ST_STROBE) && !we_q;
    o_mem_wr    = (state_q == ST_STROBE) && we_q;
    o_mem_addr  = mem_addr_q;
    o_mem_wdata = mem_wdata_q;
    o_rdata     = rdata_q;
  end

  // Bus address/data are registered when ADDR is entered so they hold outside ADDR/STROBE.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      addr_q      <= '0;
      wdata_hi_q  <= '0;
      we_q        <= 1'b0;
      word_q      <= 1'b0;
      idx_q       <= 1'b0;
      err_q       <= 1'b0;
      b0_q        <= '0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      if ((state_q == ST_IDLE) && i_req) begin
        addr_q      <= i_addr;
        wdata_hi_q  <= i_wdata[15:8];
        we_q        <= i_we;
        word_q      <= i_word;
        idx_q       <= 1'b0;
        err_q       <= 1'b0;
        mem_addr_q  <= i_addr;
        mem_wdata_q <= i_wdata[7:0];
      end else if (timeout) begin
        err_q   <= 1'b1;
        rdata_q <= '0;
      end else if (phase_done) begin
        if (!last_phase) begin
          idx_q       <= 1'b1;
          mem_addr_q  <= byte_addr(addr_q, 1'b1);
          mem_wdata_q <= wdata_hi_q;
          if (!we_q) b0_q <= i_mem_rdata;
        end else if (!we_q) begin
          rdata_q <= word_q ? {i_mem_rdata, b0_q} : {8'h00, i_mem_rdata};
        end
      end
    end
  end

endmodule

// File: tb/tb_gb80_bus_ctrl.sv
// Self-checking bench for gb80_bus_ctrl: directed scenarios plus randomized back-to-back traffic.
// Timeout scenario is compiled only when GB80_BUS_TIMEOUT_EN is defined.
module tb_gb80_bus_ctrl;

  localparam int unsigned TB_WAIT = 2;
  localparam int unsigned TB_TMO  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0, word = 1'b0, mem_wait = 1'b0;
  logic [15:0] addr = '0, wdata = '0;
  logic [7:0]  mem_rdata = '0;
  logic        ready, done, err, mem_rd, mem_wr;
  logic [15:0] rdata, maddr;
  logic [7:0]  mwdata;

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_rdata = '0;

  always #5 clk = ~clk;

  gb80_bus_ctrl #(
    .WAIT_CYCLES    (TB_WAIT),
    .TIMEOUT_CYCLES (TB_TMO)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_req       (req),
    .i_we        (we),
    .i_word      (word),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .o_ready     (ready),
    .o_done      (done),
    .o_rdata     (rdata),
    .o_err       (err),
    .o_mem_addr  (maddr),
    .o_mem_rd    (mem_rd),
    .o_mem_wr    (mem_wr),
    .o_mem_wdata (mwdata),
    .i_mem_rdata (mem_rdata),
    .i_mem_wait  (mem_wait)
  );

  // Present a request in the current IDLE cycle; returns at the negedge of cycle 1.
  task automatic start_req(input logic w, input logic wd, input logic [15:0] a, input logic [15:0] d);
    req = 1'b1; we = w; word = wd; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b1; we = 1'b1; word = 1'b1;
    addr = 16'hBEEF; wdata = 16'h5555; mem_wait = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({ready, done, err, mem_rd, mem_wr} !== 5'b10000) begin
      bad++; $display("FAIL reset_ctrl: got %b want 10000", {ready, done, err, mem_rd, mem_wr});
    end
    total++;
    if ({maddr, mwdata, rdata} !== 40'h0) begin
      bad++; $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h want zeros", maddr, mwdata, rdata);
    end
    rst_n = 1'b1; req = 1'b0; we = 1'b0; word = 1'b0; mem_wait = 1'b0;
    @(negedge clk);
    total++;
    if (ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got %b want 1", ready);
    end
    exp_rdata = '0;
  endtask

  task automatic test_byte_read();
    int rd_first = -1, rd_n = 0, done_c = -1;
    logic [15:0] a_seen = '0, got = '0;
    mem_rdata = 8'h5A;
    start_req(1'b0, 1'b0, 16'hC000, 16'h0000);
    for (int c = 1; c <= 40 && done_c < 0; c++) begin
      if (c == 1) a_seen = maddr;
      if (mem_rd) begin
        if (rd_first < 0) rd_first = c;
        rd_n++;
      end
      if (done) begin done_c = c; got = rdata; end
      @(negedge clk);
    end
    total++;
    if (rd_first != 2 || rd_n != int'(TB_WAIT) + 1) begin
      bad++; $display("FAIL byte_rd_strobe: got first=%0d len=%0d want first=2 len=%0d", rd_first, rd_n, TB_WAIT + 1);
    end
    total++;
    if (done_c != 3 + int'(TB_WAIT)) begin
      bad++; $display("FAIL byte_rd_latency: got %0d want %0d", done_c, 3 + TB_WAIT);
    end
    total++;
    if (got !== 16'h005A || a_seen !== 16'hC000) begin
      bad++; $display("FAIL byte_rd_data: got rdata=%h addr=%h want 005A C000", got, a_seen);
    end
    exp_rdata = 16'h005A;
  endtask

  task automatic test_word_write_wrap();
    logic [23:0] ev [$];
    int done_c = -1, wr_n = 0, rd_n = 0;
    logic prev_wr = 1'b0;
    logic [15:0] got = '0;
    start_req(1'b1, 1'b1, 16'hFFFF, 16'h1234);
    for (int c = 1; c <= 60 && done_c < 0; c++) begin
      if (mem_wr && !prev_wr) ev.push_back({maddr, mwdata});
      if (mem_wr) wr_n++;
      if (mem_rd) rd_n++;
      prev_wr = mem_wr;
      if (done) begin done_c = c; got = rdata; end
      @(negedge clk);
    end
    total++;
    if (ev.size() != 2) begin
      bad++; $display("FAIL wrap_events: got %0d write phases want 2", ev.size());
    end else begin
      total++;
      if (ev[0] !== 24'hFFFF34 || ev[1] !== 24'h000012) begin
        bad++; $display("FAIL wrap_bytes: got %h,%h want FFFF34,000012", ev[0], ev[1]);
      end
    end
    total++;
    if (wr_n != 2 * (int'(TB_WAIT) + 1) || rd_n != 0) begin
      bad++; $display("FAIL wrap_strobes: got wr=%0d rd=%0d want wr=%0d rd=0", wr_n, rd_n, 2 * (TB_WAIT + 1));
    end
    total++;
    if (done_c != 5 + 2 * int'(TB_WAIT)) begin
      bad++; $display("FAIL wrap_latency: got %0d want %0d", done_c, 5 + 2 * TB_WAIT);
    end
    total++;
    if (got !== exp_rdata) begin
      bad++; $display("FAIL wrap_rdata_hold: got %h want %h", got, exp_rdata);
    end
  endtask

  task automatic test_wait_states();
    int done_c = -1, rd_n = 0, k;
    logic [15:0] got = '0;
    start_req(1'b0, 1'b0, 16'h4321, 16'h0000);
    for (int c = 1; c <= 60 && done_c < 0; c++) begin
      if (mem_rd) rd_n++;
      if (done) begin done_c = c; got = rdata; end
      k = c - 2;
      mem_wait  = (c == 1) || (k >= int'(TB_WAIT) && k < int'(TB_WAIT) + 3);
      mem_rdata = (k == int'(TB_WAIT) + 3) ? 8'hA7 : 8'($urandom_range(0, 255) & 8'h5F);
      @(negedge clk);
    end
    mem_wait = 1'b0;
    total++;
    if (rd_n != int'(TB_WAIT) + 4) begin
      bad++; $display("FAIL wait_strobe_len: got %0d want %0d", rd_n, TB_WAIT + 4);
    end
    total++;
    if (done_c != int'(TB_WAIT) + 6) begin
      bad++; $display("FAIL wait_latency: got %0d want %0d", done_c, TB_WAIT + 6);
    end
    total++;
    if (got !== 16'h00A7) begin
      bad++; $display("FAIL wait_capture: got %h want 00A7", got);
    end
    exp_rdata = 16'h00A7;
  endtask

  task automatic test_req_held();
    int done_c = -1, addr_bad = 0, rdy_n = 0, dat_bad = 0;
    logic [15:0] got = '0;
    req = 1'b1; we = 1'b1; word = 1'b0; addr = 16'h1111; wdata = 16'h00C3;
    @(negedge clk);
    for (int c = 1; c <= 40 && done_c < 0; c++) begin
      if (maddr !== 16'h1111) addr_bad++;
      if (ready) rdy_n++;
      if (mem_wr && mwdata !== 8'hC3) dat_bad++;
      if (done) done_c = c;
      addr = 16'($urandom); wdata = 16'($urandom); we = 1'($urandom);
      @(negedge clk);
    end
    total++;
    if (addr_bad != 0 || rdy_n != 0 || dat_bad != 0) begin
      bad++; $display("FAIL held_ignored: got addr_bad=%0d ready=%0d data_bad=%0d want 0 0 0", addr_bad, rdy_n, dat_bad);
    end
    total++;
    if (done_c != 3 + int'(TB_WAIT)) begin
      bad++; $display("FAIL held_latency: got %0d want %0d", done_c, 3 + TB_WAIT);
    end
    total++;
    if (ready !== 1'b1) begin
      bad++; $display("FAIL held_idle_after_done: got ready=%b want 1", ready);
    end
    addr = 16'h2222; we = 1'b0; word = 1'b0;
    mem_rdata = 8'h3C;
    @(negedge clk);
    req = 1'b0;
    total++;
    if (ready !== 1'b0 || maddr !== 16'h2222) begin
      bad++; $display("FAIL held_second_accept: got ready=%b addr=%h want 0 2222", ready, maddr);
    end
    done_c = -1;
    for (int c = 1; c <= 40 && done_c < 0; c++) begin
      if (done) begin done_c = c; got = rdata; end
      @(negedge clk);
    end
    total++;
    if (got !== 16'h003C) begin
      bad++; $display("FAIL held_second_data: got %h want 003C", got);
    end
    exp_rdata = 16'h003C;
  endtask

`ifdef GB80_BUS_TIMEOUT_EN
  task automatic test_timeout();
    for (int w = 0; w < 2; w++) begin
      int done_c = -1, rd_n = 0, addr_bad = 0;
      logic e = 1'b0;
      logic [15:0] got = 16'hFFFF;
      start_req(1'b0, 1'(w), 16'h8000, 16'h0000);
      mem_wait = 1'b1;
      for (int c = 1; c <= 80 && done_c < 0; c++) begin
        if (mem_rd) rd_n++;
        if (maddr !== 16'h8000) addr_bad++;
        if (done) begin done_c = c; got = rdata; e = err; end
        mem_rdata = 8'($urandom);
        @(negedge clk);
      end
      mem_wait = 1'b0;
      total++;
      if (done_c != 2 + int'(TB_WAIT) + int'(TB_TMO) || rd_n != int'(TB_WAIT) + int'(TB_TMO)) begin
        bad++; $display("FAIL timeout_latency: got done=%0d strobe=%0d want %0d %0d", done_c, rd_n, 2 + TB_WAIT + TB_TMO, TB_WAIT + TB_TMO);
      end
      total++;
      if (e !== 1'b1 || got !== 16'h0000 || addr_bad != 0) begin
        bad++; $display("FAIL timeout_result: got err=%b rdata=%h addr_bad=%0d want 1 0000 0", e, got, addr_bad);
      end
    end
    exp_rdata = '0;
  endtask
`endif

  task automatic test_reset_mid();
    int done_n = 0;
    mem_wait = 1'b0;
    start_req(1'b0, 1'b1, 16'h7FF0, 16'h0000);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({done, mem_rd, mem_wr} !== 3'b000) begin
      bad++; $display("FAIL rstmid_strobes: got done/rd/wr=%b want 000", {done, mem_rd, mem_wr});
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({ready, err, maddr, mwdata, rdata} !== {1'b1, 1'b0, 40'h0}) begin
      bad++; $display("FAIL rstmid_values: got ready=%b err=%b addr=%h wdata=%h rdata=%h want 1 0 zeros", ready, err, maddr, mwdata, rdata);
    end
    repeat (4) begin
      if (done) done_n++;
      @(negedge clk);
    end
    total++;
    if (done_n != 0) begin
      bad++; $display("FAIL rstmid_no_done: got %0d done pulses want 0", done_n);
    end
    exp_rdata = '0;
  endtask

  task automatic test_random_back_to_back(input int n);
    for (int t = 0; t < n; t++) begin
      logic        r_we, r_word;
      logic [15:0] r_addr, r_wdata, e_rd, ea;
      logic [7:0]  rb [2];
      logic [7:0]  ew;
      logic [15:0] wbits [2];
      int          len [2];
      int          nb, highs;
      r_we    = 1'($urandom);
      r_word  = 1'($urandom);
      r_addr  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      r_wdata = 16'($urandom);
      nb      = r_word ? 2 : 1;
      for (int b = 0; b < 2; b++) begin
        highs = 0; rb[b] = 8'($urandom); wbits[b] = '0; len[b] = 0;
        for (int k = 0; k < 16 && len[b] == 0; k++) begin
          if (k < int'(TB_WAIT)) wbits[b][k] = 1'($urandom);
          else if (highs < 3 && $urandom_range(0, 1) == 1) begin wbits[b][k] = 1'b1; highs++; end
          else len[b] = k + 1;
        end
      end
      e_rd = r_we ? exp_rdata : (r_word ? {rb[1], rb[0]} : {8'h00, rb[0]});
      total++;
      if (ready !== 1'b1) begin
        bad++; $display("FAIL rnd_idle[%0d]: got ready=%b want 1", t, ready);
      end
      req = 1'b1; we = r_we; word = r_word; addr = r_addr; wdata = r_wdata; mem_wait = 1'($urandom);
      @(negedge clk);
      for (int b = 0; b < nb; b++) begin
        ea = r_addr + 16'(b);
        ew = (b == 0) ? r_wdata[7:0] : r_wdata[15:8];
        total++;
        if ({ready, done, mem_rd, mem_wr, maddr} !== {4'b0000, ea}) begin
          bad++; $display("FAIL rnd_addr_phase[%0d.%0d]: got rdy/dn/rd/wr=%b addr=%h want 0000 %h", t, b, {ready, done, mem_rd, mem_wr}, maddr, ea);
        end
        if (r_we) begin
          total++;
          if (mwdata !== ew) begin
            bad++; $display("FAIL rnd_wbyte[%0d.%0d]: got %h want %h", t, b, mwdata, ew);
          end
        end
        req = 1'($urandom); addr = 16'($urandom); we = 1'($urandom);
        mem_wait = 1'($urandom); mem_rdata = 8'($urandom);
        @(negedge clk);
        for (int k = 0; k < len[b]; k++) begin
          total++;
          if ({ready, done, mem_rd, mem_wr, maddr} !== {2'b00, !r_we, r_we, ea}) begin
            bad++; $display("FAIL rnd_strobe[%0d.%0d.%0d]: got rdy/dn/rd/wr=%b addr=%h want 00%b%b %h", t, b, k, {ready, done, mem_rd, mem_wr}, maddr, !r_we, r_we, ea);
          end
          mem_wait  = wbits[b][k];
          mem_rdata = (k == len[b] - 1) ? rb[b] : 8'($urandom);
          req = 1'($urandom); addr = 16'($urandom);
          @(negedge clk);
        end
      end
      total++;
      if ({ready, done, err, mem_rd, mem_wr} !== 5'b01000) begin
        bad++; $display("FAIL rnd_done[%0d]: got rdy/dn/err/rd/wr=%b want 01000", t, {ready, done, err, mem_rd, mem_wr});
      end
      total++;
      if (rdata !== e_rd) begin
        bad++; $display("FAIL rnd_rdata[%0d]: got %h want %h", t, rdata, e_rd);
      end
      exp_rdata = e_rd;
      req = 1'b0; mem_wait = 1'($urandom);
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        total++;
        if (ready !== 1'b1 || done !== 1'b0) begin
          bad++; $display("FAIL rnd_gap[%0d]: got ready=%b done=%b want 1 0", t, ready, done);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_byte_read();
    test_word_write_wrap();
    test_wait_states();
    test_req_held();
`ifdef GB80_BUS_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    test_random_back_to_back(60);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
